pwm_capture: RTL and testbench



---
 rtl/pwm_capture.sv | 197 +++++++++++++++++++
 tb/tb_pwm_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: receive-side PWM decoder.
// Measures the high time and the period between successive rising edges of an
// asynchronous PWM input and reports an 8-bit pulse-width code. A missing edge
// for TIMEOUT cycles reports the stuck level as 8'hFF (high) or 8'h00 (low).
// Optional build macro PWM_CAPTURE_GLITCH_FILTER_EN inserts a 3-sample stability
// filter ahead of edge detection so that pulses shorter than 3 cycles are ignored.
module pwm_capture #(
   parameter int PERIOD     = 256,
   parameter int PERIOD_TOL = 2,
   parameter int TIMEOUT    = 512
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pulse_in,
   output logic [7:0] width_out,
   output logic       valid,
   output logic       locked,
   output logic       period_err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]        TMAX  = CW'(TIMEOUT);
   localparam logic [CW-1:0]        ONE   = CW'(1);
   localparam logic [CW-1:0]        H_MAX = CW'(256);
   localparam logic signed [CW+1:0] PER_S = (CW+2)'(PERIOD);
   localparam logic signed [CW+1:0] TOL_S = (CW+2)'(PERIOD_TOL);

   typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;

   // Saturating increment: counters stop at TIMEOUT and never wrap.
   function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] c);
      if (c == TMAX) return c;
      else           return c + ONE;
   endfunction

   // Period acceptance window PERIOD +/- PERIOD_TOL, both ends inclusive.
   function automatic logic in_tol(input logic [CW-1:0] p);
      logic signed [CW+1:0] d;
      d = $signed({2'b00, p}) - PER_S;
      return (d <= TOL_S) && (d >= -TOL_S);
   endfunction

   // High count 1..256 maps to code 0..255; longer highs clamp to full scale.
   function automatic logic [7:0] sat_code(input logic [CW-1:0] h);
      if (h > H_MAX) return 8'hFF;
      else           return 8'(h - ONE);
   endfunction

   logic meta_q, ps_q;
   logic lvl, lvl_prev, rise, fall;

   // Two-flop synchronizer for the asynchronous PWM input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         ps_q   <= 1'b0;
      end else begin
         meta_q <= pulse_in;
         ps_q   <= meta_q;
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   logic       filt_q, filt_d;
   logic [1:0] stab_q, stab_d;

   // Stability filter: adopt the synchronized level after 3 consecutive differing samples.
   always_comb begin
      filt_d = filt_q;
      stab_d = 2'd0;
      if (ps_q != filt_q) begin
         if (stab_q == 2'd2) filt_d = ps_q;
         else                stab_d = stab_q + 2'd1;
      end
   end

   // Filter state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q <= 1'b0;
         stab_q <= 2'd0;
      end else begin
         filt_q <= filt_d;
         stab_q <= stab_d;
      end
   end

   // Edges are taken from the filter decision itself, so each edge is delayed by 2 cycles.
   assign lvl      = filt_d;
   assign lvl_prev = filt_q;
`else
   logic ps_dly_q;

   // One-cycle delayed copy of the synchronized level for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ps_dly_q <= 1'b0;
      else     ps_dly_q <= ps_q;
   end

   assign lvl      = ps_q;
   assign lvl_prev = ps_dly_q;
`endif

   assign rise = lvl & ~lvl_prev;
   assign fall = ~lvl & lvl_prev;

   state_t          state_q, state_d;
   logic [CW-1:0]   period_q, period_d;
   logic [CW-1:0]   high_q, high_d;
   logic [7:0]      width_q, width_d;
   logic            valid_q, valid_d;
   logic            locked_q, locked_d;
   logic            perr_q, perr_d;

   // Next-state, counter and output decode; a rise always wins over a timeout.
   always_comb begin
      state_d  = state_q;
      period_d = inc_sat(period_q);
      high_d   = high_q;
      width_d  = width_q;
      valid_d  = 1'b0;
      locked_d = locked_q;
      perr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) begin
               period_d = ONE;
               high_d   = ONE;
               state_d  = MEASURE;
            end else if (period_q == TMAX) begin
               state_d  = STUCK;
               width_d  = lvl ? 8'hFF : 8'h00;
               valid_d  = 1'b1;
               locked_d = 1'b0;
            end
         end
         MEASURE: begin
            if (lvl) high_d = inc_sat(high_q);
            if (rise) begin
               if (in_tol(period_q)) begin
                  width_d  = sat_code(high_q);
                  valid_d  = 1'b1;
                  locked_d = 1'b1;
               end else begin
                  perr_d   = 1'b1;
                  locked_d = 1'b0;
               end
               period_d = ONE;
               high_d   = ONE;
            end else if (period_q == TMAX) begin
               state_d  = STUCK;
               width_d  = lvl ? 8'hFF : 8'h00;
               valid_d  = 1'b1;
               locked_d = 1'b0;
            end
         end
         STUCK: begin
            if (rise) begin
               period_d = ONE;
               high_d   = ONE;
               state_d  = MEASURE;
            end else if (fall) begin
               period_d = ONE;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counter and output registers; reset discards any partial measurement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         period_q <= '0;
         high_q   <= '0;
         width_q  <= 8'h00;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         high_q   <= high_d;
         width_q  <= width_d;
         valid_q  <= valid_d;
         locked_q <= locked_d;
         perr_q   <= perr_d;
      end
   end

   assign width_out  = width_q;
   assign valid      = valid_q;
   assign locked     = locked_q;
   assign period_err = perr_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed stimulus for pwm_capture with an expected-event
// scoreboard. Each completed input period pushes the expected decode (or error),
// and a monitor pops and compares whenever the DUT strobes valid or period_err.
module tb_pwm_capture;

   logic       clk;
   logic       rst;
   logic       pulse_in;
   logic [7:0] width_out;
   logic       valid;
   logic       locked;
   logic       period_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       err;
      logic [7:0] w;
      logic       lk;
   } exp_t;

   exp_t sb[$];

   logic [7:0] exp_w  = 8'h00;
   bit         armed  = 0;
   int         prev_p = 0;
   int         prev_h = 0;

   pwm_capture dut (
      .clk        (clk),
      .rst        (rst),
      .pulse_in   (pulse_in),
      .width_out  (width_out),
      .valid      (valid),
      .locked     (locked),
      .period_err (period_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input logic err, input logic [7:0] w, input logic lk);
      exp_t e;
      e.err = err;
      e.w   = w;
      e.lk  = lk;
      sb.push_back(e);
   endtask

   // A rising input edge closes the period described by prev_p/prev_h.
   task automatic on_rise();
      if (armed) begin
         if (prev_p >= 254 && prev_p <= 258) begin
            exp_w = (prev_h > 256) ? 8'hFF : 8'(prev_h - 1);
            push_exp(1'b0, exp_w, 1'b1);
         end else begin
            push_exp(1'b1, exp_w, 1'b0);
         end
      end
      armed = 1;
   endtask

   // Hold pulse_in at lv for n clock cycles (called #1 after a rising edge).
   task automatic drive(input logic lv, input int n);
      pulse_in = lv;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int h, input int l);
      on_rise();
      prev_p = h + l;
      prev_h = h;
      drive(1'b1, h);
      drive(1'b0, l);
   endtask

   task automatic hold(input logic lv, input int n, input bit to_stuck);
      if (lv && !pulse_in) on_rise();
      if (to_stuck) begin
         exp_w = lv ? 8'hFF : 8'h00;
         push_exp(1'b0, exp_w, 1'b0);
         armed = 0;
      end
      drive(lv, n);
   endtask

   // One period with a single-cycle high glitch g cycles into the low phase.
   task automatic pulse_glitch(input int h, input int l, input int g);
      on_rise();
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      prev_p = h + l;
      prev_h = h;
      drive(1'b1, h);
      drive(1'b0, g);
      drive(1'b1, 1);
      drive(1'b0, l - g - 1);
`else
      prev_p = h + g;
      prev_h = h;
      drive(1'b1, h);
      drive(1'b0, g);
      on_rise();
      prev_p = l - g;
      prev_h = 1;
      drive(1'b1, 1);
      drive(1'b0, l - g - 1);
`endif
   endtask

   // One period whose low phase is interrupted by an asynchronous reset.
   task automatic pulse_rst(input int h, input int l, input int at);
      on_rise();
      drive(1'b1, h);
      drive(1'b0, at);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_width",  32'(width_out),  32'h00);
      chk("async_rst_locked", 32'(locked),     32'h0);
      chk("async_rst_valid",  32'(valid),      32'h0);
      chk("async_rst_perr",   32'(period_err), 32'h0);
      armed = 0;
      exp_w = 8'h00;
      #9 rst = 1'b0;
      drive(1'b0, l - at - 1);
   endtask

   // Monitor: every output strobe must match the oldest expected event.
   always @(negedge clk) begin
      if (!rst && (valid || period_err)) begin
         chk("strobe_exclusive", 32'(valid & period_err), 32'h0);
         if (sb.size() == 0) begin
            chk("unexpected_strobe", 32'(sb.size()), 32'h1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("strobe_kind",  32'(period_err), 32'(e.err));
            chk("width_out",    32'(width_out),  32'(e.w));
            chk("locked",       32'(locked),     32'(e.lk));
         end
      end
   end

   initial begin
      rst      = 1'b1;
      pulse_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_width",  32'(width_out),  32'h00);
      chk("reset_valid",  32'(valid),      32'h0);
      chk("reset_locked", 32'(locked),     32'h0);
      chk("reset_perr",   32'(period_err), 32'h0);
      rst = 1'b0;
      drive(1'b0, 5);

      // Nominal code 0x40 stream: first rise only arms.
      for (int i = 0; i < 4; i++) pulse(65, 191);
      chk("locked_after_stream", 32'(locked), 32'h1);

      // Stuck high, then stuck low.
      hold(1'b1, 600, 1'b1);
      hold(1'b0, 600, 1'b1);

      // Relock, then stuck low directly out of a locked stream.
      for (int i = 0; i < 3; i++) pulse(65, 191);
      hold(1'b0, 600, 1'b1);

      // Relock, one long period, then recovery with a new code.
      for (int i = 0; i < 3; i++) pulse(65, 191);
      pulse(100, 200);
      pulse(17, 239);

      // Tolerance boundaries: 254 and 258 accepted, 253 and 259 rejected.
      pulse(65, 189);
      pulse(65, 193);
      pulse(65, 188);
      pulse(65, 194);
      pulse(65, 191);

      // Reset in the middle of a measurement.
      pulse_rst(65, 191, 50);
      chk("post_reset_locked", 32'(locked), 32'h0);

      // Code 0x80 stream with a single-cycle glitch.
      pulse(129, 127);
      pulse_glitch(129, 127, 20);
      pulse(129, 127);
      pulse(129, 127);

      // Final rise closes the last period; then all expectations must be consumed.
      hold(1'b1, 30, 1'b0);
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
